// File: rtl/fetch_pc_gen_if.sv
// Fetch front-end bundle: redirect/stall control, I-cache request/response channel
// and the two-slot packet handed to the fetch buffer.
interface fetch_pc_gen_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic        icache_valid;
  logic [63:0] icache_data;
  logic        icache_ack;
  logic [31:0] pc;
  logic [63:0] irin;
  logic        if0;
  logic        if1;
  logic        flag;

  modport master (
    input  stall, redirect, redirect_pc, icache_ready, icache_valid, icache_data,
    output icache_req, icache_addr, icache_ack, pc, irin, if0, if1, flag
  );

  modport slave (
    output stall, redirect, redirect_pc, icache_ready, icache_valid, icache_data,
    input  icache_req, icache_addr, icache_ack, pc, irin, if0, if1, flag
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Sequential fetch PC generator: one outstanding aligned I-cache request at a time,
// each returned line becomes a two-slot packet for the fetch buffer.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic           clk,
  input  logic           rstn,
  fetch_pc_gen_if.master io_bus
);

  typedef enum logic [1:0] {REQ, WAIT, DROP} StateT;

  StateT       r_state;
  StateT       w_nextState;
  logic [31:0] r_fetchPc;
  logic [31:0] r_reqPc;
  logic [31:0] r_pc;
  logic [63:0] r_irin;
  logic        r_if0;
  logic        r_if1;
  logic        r_flag;

  logic        w_req;
  logic        w_ack;
  logic        w_take;
  logic        w_stall;
  logic        w_redirect;
  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_redirectTarget;

  assign w_stall          = io_bus.stall;
  assign w_redirect       = io_bus.redirect;
  assign w_ready          = io_bus.icache_ready;
  assign w_valid          = io_bus.icache_valid;
  assign w_redirectTarget = io_bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= REQ;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      REQ: begin
        if (w_req && w_ready) w_nextState = WAIT;
      end
      WAIT: begin
        if (w_redirect)  w_nextState = w_valid ? REQ : DROP;
        else if (w_ack)  w_nextState = REQ;
      end
      DROP: begin
        if (w_valid) w_nextState = REQ;
      end
      default: w_nextState = REQ;
    endcase
  end

  // In WAIT a response is always taken under redirect (to discard it); otherwise only
  // when the packet slot is free or being drained at this edge.
  always_comb begin
    w_req = 1'b0;
    w_ack = 1'b0;
    if (rstn) begin
      case (r_state)
        REQ:     w_req = !w_redirect;
        WAIT:    w_ack = w_valid && (w_redirect || !r_flag || !w_stall);
        DROP:    w_ack = w_valid;
        default: begin
          w_req = 1'b0;
          w_ack = 1'b0;
        end
      endcase
    end
  end

  assign w_take = (r_state == WAIT) && w_ack && !w_redirect;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fetchPc <= RESET_PC;
      r_reqPc   <= 32'd0;
      r_pc      <= 32'd0;
      r_irin    <= 64'd0;
      r_if0     <= 1'b0;
      r_if1     <= 1'b0;
      r_flag    <= 1'b0;
    end else if (w_redirect) begin
      r_fetchPc <= w_redirectTarget;
      r_flag    <= 1'b0;
      r_if0     <= 1'b0;
      r_if1     <= 1'b0;
    end else begin
      if (w_req && w_ready) r_reqPc <= r_fetchPc;
      if (w_take) begin
        r_irin    <= io_bus.icache_data;
        r_pc      <= r_reqPc;
        r_if0     <= ~r_reqPc[2];
        r_if1     <= 1'b1;
        r_flag    <= 1'b1;
        r_fetchPc <= (r_reqPc & 32'hFFFF_FFF8) + 32'd8;
      end else if (r_flag && !w_stall) begin
        r_flag <= 1'b0;
        r_if0  <= 1'b0;
        r_if1  <= 1'b0;
      end
    end
  end

  assign io_bus.icache_req  = w_req;
  assign io_bus.icache_addr = r_fetchPc & 32'hFFFF_FFF8;
  assign io_bus.icache_ack  = w_ack;
  assign io_bus.pc          = r_pc;
  assign io_bus.irin        = r_irin;
  assign io_bus.if0         = r_if0;
  assign io_bus.if1         = r_if1;
  assign io_bus.flag        = r_flag;

endmodule
